// File: rtl/an_sec_decoder_seq_pkg.sv
// Shared constants, FSM state encoding and result record for the sequential AN-code SEC decoder.
// Changing the code constant or widths here re-targets the whole decoder.
package an_code_pkg;
   localparam int DATA_W = 28;
   localparam int A      = 17619;
   localparam int R_W    = 15;
   localparam int CW_W   = DATA_W + R_W;
   localparam int POS_W  = 6;
   localparam int Q_W    = DATA_W + 1;
   localparam int N_W    = DATA_W + 2;

   typedef enum logic [1:0] {IDLE, DIV, SRCH, OUT} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] n;
      logic              corr;
      logic              uncorr;
      logic [POS_W-1:0]  pos;
      logic              sign;
   } result_t;
endpackage

// File: rtl/an_sec_decoder_seq_if.sv
// Codeword-in / operand-out stream bundle of the AN-code decoder.
interface an_sec_decoder_seq_if;
   import an_code_pkg::*;

   // A transfer happens on a rising edge where valid && ready; the sender holds its
   // payload stable and keeps valid high until that edge, and never retracts valid early.
   logic              in_valid;
   logic              in_ready;
   logic [CW_W-1:0]   in_w;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_n;
   logic              out_corr;
   logic              out_uncorr;
   logic [POS_W-1:0]  out_pos;
   logic              out_sign;

   modport slave (
      input  in_valid, in_w, out_ready,
      output in_ready, out_valid, out_n, out_corr, out_uncorr, out_pos, out_sign
   );

   modport master (
      output in_valid, in_w, out_ready,
      input  in_ready, out_valid, out_n, out_corr, out_uncorr, out_pos, out_sign
   );
endinterface

// File: rtl/an_sec_decoder_seq_divider.sv
// Serial restoring divider by a constant: one quotient bit per cycle, CW_W cycles per start.
// Quotient and remainder stay stable after done until the next start.
module an_serial_divider #(
   parameter int CW_W = 43,
   parameter int R_W  = 15,
   parameter int Q_W  = 29,
   parameter int A    = 17619
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [CW_W-1:0] dividend,
   output logic            done,
   output logic [Q_W-1:0]  quo,
   output logic [R_W-1:0]  rem
);
   localparam int              CNT_W    = $clog2(CW_W);
   localparam logic [R_W:0]    A_V      = (R_W+1)'(A);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW_W - 1);

   // sh shifts dividend bits out of the top while quotient bits enter at the bottom
   logic [CW_W-1:0]  sh;
   logic [R_W-1:0]   rem_r;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic [R_W:0]     trial;
   logic             ge;

   always_comb begin
      trial = {rem_r, sh[CW_W-1]};
      ge    = (trial >= A_V);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh    <= '0;
         rem_r <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            sh    <= dividend;
            rem_r <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
         end else if (busy) begin
            rem_r <= R_W'(ge ? trial - A_V : trial);
            sh    <= {sh[CW_W-2:0], ge};
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quo = sh[Q_W-1:0];
   assign rem = rem_r;
endmodule

// File: rtl/an_sec_decoder_seq.sv
// Multi-cycle single-error-correcting AN-code decoder: serial divide, then walk 2^i mod A
// one index per cycle looking for a residue that explains the error as +/-2^i.
module an_sec_decoder_seq
   import an_code_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   an_sec_decoder_seq_if.slave   bus,
   output state_t                dbg_state
);
   localparam logic [R_W-1:0]   A_R    = R_W'(A);
   localparam logic [R_W:0]     A_P    = (R_W+1)'(A);
   localparam logic [POS_W-1:0] LAST_I = POS_W'(CW_W - 1);

   state_t          state;
   logic [CW_W-1:0] w_q;
   logic            div_start;
   logic            div_done;
   logic [Q_W-1:0]  q;
   logic [R_W-1:0]  r;
   logic            in_ready_r;
   logic            out_valid_r;
   result_t         res;

   // Search state: p = 2^i mod A, k = floor(2^i / A)
   logic [R_W-1:0]   p;
   logic [N_W-1:0]   k;
   logic [POS_W-1:0] i;

   logic [R_W:0]   p2;
   logic           p_wrap;
   logic [R_W-1:0] p_nx;
   logic [N_W-1:0] k_nx;
   logic           match_pos;
   logic           match_neg;
   logic [N_W-1:0] q_ext;
   logic [N_W-1:0] n_pos;
   logic [N_W-1:0] n_neg;
   logic           pos_bad;
   logic           neg_bad;
   result_t        res_uncorr;

   an_serial_divider #(.CW_W(CW_W), .R_W(R_W), .Q_W(Q_W), .A(A)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (w_q),
      .done     (div_done),
      .quo      (q),
      .rem      (r)
   );

   always_comb begin
      p2         = {p, 1'b0};
      p_wrap     = (p2 >= A_P);
      p_nx       = R_W'(p_wrap ? p2 - A_P : p2);
      k_nx       = {k[N_W-2:0], p_wrap};
      match_pos  = (r == p);
      match_neg  = (r == (A_R - p));
      q_ext      = {1'b0, q};
      n_pos      = q_ext - k;
      n_neg      = q_ext + k + N_W'(1);
      // A positive correction is illegal if it underflows or leaves the operand range
      pos_bad    = (k > q_ext) || (n_pos[N_W-1:DATA_W] != '0);
      neg_bad    = (n_neg[N_W-1:DATA_W] != '0);
      res_uncorr = '{n: q[DATA_W-1:0], corr: 1'b0, uncorr: 1'b1, pos: '0, sign: 1'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         w_q         <= '0;
         div_start   <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         res         <= '0;
         p           <= '0;
         k           <= '0;
         i           <= '0;
      end else begin
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  w_q        <= bus.in_w;
                  in_ready_r <= 1'b0;
                  div_start  <= 1'b1;
                  state      <= DIV;
               end
            end
            DIV: begin
               if (div_done) begin
                  if (r == '0) begin
                     res <= q[DATA_W] ? res_uncorr
                                      : '{n: q[DATA_W-1:0], corr: 1'b0, uncorr: 1'b0,
                                          pos: '0, sign: 1'b0};
                     out_valid_r <= 1'b1;
                     state       <= OUT;
                  end else begin
                     p     <= R_W'(1);
                     k     <= '0;
                     i     <= '0;
                     state <= SRCH;
                  end
               end
            end
            SRCH: begin
               if (match_pos) begin
                  res <= pos_bad ? res_uncorr
                                 : '{n: n_pos[DATA_W-1:0], corr: 1'b1, uncorr: 1'b0,
                                     pos: i, sign: 1'b0};
                  out_valid_r <= 1'b1;
                  state       <= OUT;
               end else if (match_neg) begin
                  res <= neg_bad ? res_uncorr
                                 : '{n: n_neg[DATA_W-1:0], corr: 1'b1, uncorr: 1'b0,
                                     pos: i, sign: 1'b1};
                  out_valid_r <= 1'b1;
                  state       <= OUT;
               end else if (i == LAST_I) begin
                  res         <= res_uncorr;
                  out_valid_r <= 1'b1;
                  state       <= OUT;
               end else begin
                  p <= p_nx;
                  k <= k_nx;
                  i <= i + 1'b1;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_n      = res.n;
   assign bus.out_corr   = res.corr;
   assign bus.out_uncorr = res.uncorr;
   assign bus.out_pos    = res.pos;
   assign bus.out_sign   = res.sign;
   assign dbg_state      = state;
endmodule
